// File: rtl/div_unit.sv
// Iterative restoring divider: WIDTH shift-subtract steps plus one result cycle.
// Signed (DIV) support is compiled in only when DIV_SIGNED_EN is defined.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dz_q;

  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fin_c;
  logic [WIDTH-1:0] rem_fin_c;

`ifdef DIV_SIGNED_EN
  logic dvd_neg_c;
  logic dvs_neg_c;
  logic neg_quo_q;
  logic neg_rem_q;

  // Operands enter the datapath as magnitudes; signs are reapplied at the end
  always_comb begin
    dvd_neg_c = is_signed & dividend[WIDTH-1];
    dvs_neg_c = is_signed & divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? (WIDTH'(0) - dividend) : dividend;
    dvs_mag_c = dvs_neg_c ? (WIDTH'(0) - divisor)  : divisor;
  end

  // Divide-by-zero overrides sign fix-up; remainder fix-up restores the raw dividend
  always_comb begin
    rem_fin_c = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
    if (dz_q) begin
      quo_fin_c = '1;
    end else begin
      quo_fin_c = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;

  always_comb begin
    dvd_mag_c = dividend;
    dvs_mag_c = divisor;
    rem_fin_c = rem_q;
    quo_fin_c = dz_q ? '1 : quo_q;
  end
`endif

  // One restoring step: shift the next dividend bit into the partial remainder
  always_comb begin
    rem_sh_c = {rem_q, quo_q[WIDTH-1]};
    diff_c   = rem_sh_c - {1'b0, dvs_q};
    rem_d    = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state_q   <= S_RUN;
            busy      <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= dvd_mag_c;
            dvs_q     <= dvs_mag_c;
            dz_q      <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_quo_q <= dvd_neg_c ^ dvs_neg_c;
            neg_rem_q <= dvd_neg_c;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // start is deliberately not looked at here
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_fin_c;
            remainder <= rem_fin_c;
            div_zero  <= dz_q;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled on rising edge of clk.
REQ-005 SHALL have port: is_signed  input  1  1 = DIV semantics, 0 = DIVU semantics; sampled with start.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port: busy  output  1  operation in progress; destined for the CPU stall logic.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 SHALL have port: quotient  output  WIDTH  result destined for LO.
REQ-011 SHALL have port: remainder  output  WIDTH  result destined for HI.
REQ-012 SHALL have port: div_zero  output  1  last operation had divisor == 0; valid with done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE or DONE with start=1, latch operand magnitudes, is_signed and the sign flags, clear the iteration counter, and enter RUN.
REQ-015 SHALL ignore start while in RUN; latched operands and the counter are unaffected.
REQ-016 SHALL perform one restoring shift-subtract iteration per RUN cycle, exactly WIDTH iterations, then enter DONE.
REQ-017 SHALL assert done for exactly one cycle, beginning WIDTH+1 rising edges after the start edge (33 for WIDTH=32).
REQ-018 SHALL hold busy=1 from the start edge until the edge that enters DONE; busy=0 in IDLE and DONE.
REQ-019 SHALL return to IDLE from DONE after one cycle unless start=1 (back-to-back accept).
REQ-020 SHALL hold quotient, remainder and div_zero stable from done until the next completed operation.
REQ-021 SHALL, for unsigned operation, produce quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor.
REQ-022 SHALL, for signed operation, negate the quotient when operand signs differ and give the remainder the sign of the dividend (truncation toward zero).
REQ-023 SHALL, for signed most-negative / -1, wrap: quotient = 1 followed by WIDTH-1 zeros, remainder = 0.
REQ-024 SHALL, for divisor == 0, take full latency and output quotient = all ones, remainder = dividend, div_zero = 1.

Reset
REQ-025 SHALL, on rst asserted (asynchronous), force IDLE, counter = 0, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0.
REQ-026 SHALL abort an operation in progress on reset; no done pulse occurs for the aborted operation.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro DIV_SIGNED_EN defined, support signed division per REQ-022/REQ-023.
REQ-029 SHALL, without DIV_SIGNED_EN, ignore is_signed, always perform unsigned division, omit sign-correction logic, and keep the identical port list and latency.

Verification
REQ-030 SHALL cover: unsigned 100 / 7, start at edge 0 -> done at edge 33, quotient = 14, remainder = 2, div_zero = 0.
REQ-031 SHALL cover: signed -7 / 2 -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF; with DIV_SIGNED_EN undefined -> quotient = 0x7FFFFFFC, remainder = 0x00000001.
REQ-032 SHALL cover: 0x12345678 / 0 -> done at edge 33, quotient = 0xFFFFFFFF, remainder = 0x12345678, div_zero = 1.
REQ-033 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
REQ-034 SHALL cover: start held high during RUN with new operands -> first result unchanged and done pulses once; start in the DONE cycle -> second done 33 edges later.
REQ-035 SHALL cover: rst asserted at edge 10 of an operation -> busy = 0 and outputs = 0 immediately, no done pulse follows, and a new start after release completes correctly.
